// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative IEEE-754 single divider, restoring radix-2, valid/ready handshakes
// Optional FDIV_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fdiv_seq #(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        nan,
    output logic        zero,
    output logic        underflow,
    output logic        overflow,
    output logic        divzero
);

    localparam int STEPS = 26 / ITERS_PER_CYCLE;

`ifdef FDIV_ROUND_NEAREST_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [25:0]        rem_r, rem_nxt;
    logic [23:0]        div_r;
    logic [25:0]        q_r, q_nxt;
    logic [4:0]         cnt_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;

    // Operand classification on the live inputs, used only at accept
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in;
    logic       spec_hit;
    logic [31:0] spec_z;
    logic [4:0]  spec_flags;

    always_comb begin
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        s_in   = a[31] ^ b[31];
        spec_hit   = 1'b1;
        spec_z     = 32'h0;
        spec_flags = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_z     = 32'h7FC00000;
            spec_flags = 5'b10000;
        end else if (b_zero && !a_inf) begin
            spec_z     = {s_in, 8'hFF, 23'd0};
            spec_flags = 5'b00001;
        end else if (a_inf) begin
            spec_z     = {s_in, 8'hFF, 23'd0};
            spec_flags = 5'b00010;
        end else if (a_zero || b_inf) begin
            spec_z     = {s_in, 31'd0};
            spec_flags = 5'b01000;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ITERS_PER_CYCLE restoring steps chained per cycle
    always_comb begin
        rem_nxt = rem_r;
        q_nxt   = q_r;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            if (rem_nxt >= {2'b00, div_r}) begin
                rem_nxt = rem_nxt - {2'b00, div_r};
                q_nxt   = {q_nxt[24:0], 1'b1};
            end else begin
                q_nxt   = {q_nxt[24:0], 1'b0};
            end
            rem_nxt = rem_nxt << 1;
        end
    end

    logic [22:0]        m_pre, m_fin;
    logic [23:0]        m_sum;
    logic               g, st, inc;
    logic signed [9:0]  e_pre, e_fin;
    logic [31:0]        norm_z;
    logic [4:0]         norm_flags;

    always_comb begin
        if (q_r[25]) begin
            m_pre = q_r[24:2];
            g     = q_r[1];
            st    = q_r[0] | (rem_r != 26'd0);
            e_pre = exp_r;
        end else begin
            m_pre = q_r[23:1];
            g     = q_r[0];
            st    = (rem_r != 26'd0);
            e_pre = exp_r - 10'sd1;
        end
        inc   = ROUND_EN & g & (st | m_pre[0]);
        m_sum = {1'b0, m_pre} + {23'd0, inc};
        // Rounding carry-out renormalises to 1.0 x 2^(e+1)
        m_fin = m_sum[23] ? 23'd0 : m_sum[22:0];
        e_fin = m_sum[23] ? (e_pre + 10'sd1) : e_pre;
        if (e_fin >= 10'sd255) begin
            norm_z     = {sign_r, 8'hFF, 23'd0};
            norm_flags = 5'b00010;
        end else if (e_fin <= 10'sd0) begin
            norm_z     = {sign_r, 31'd0};
            norm_flags = 5'b01100;
        end else begin
            norm_z     = {sign_r, e_fin[7:0], m_fin};
            norm_flags = 5'b00000;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = spec_hit ? S_DONE : S_DIV;
            S_DIV:  if (cnt_r == 5'(STEPS - 1)) state_nxt = S_NORM;
            S_NORM: state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rem_r     <= 26'd0;
            div_r     <= 24'd0;
            q_r       <= 26'd0;
            cnt_r     <= 5'd0;
            sign_r    <= 1'b0;
            exp_r     <= 10'sd0;
            z         <= 32'h0;
            nan       <= 1'b0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            divzero   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_r <= s_in;
                        exp_r  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                        rem_r  <= {3'b001, a[22:0]};
                        div_r  <= {1'b1, b[22:0]};
                        q_r    <= 26'd0;
                        cnt_r  <= 5'd0;
                        if (spec_hit) begin
                            z <= spec_z;
                            {nan, zero, underflow, overflow, divzero} <= spec_flags;
                        end
                    end
                end
                S_DIV: begin
                    rem_r <= rem_nxt;
                    q_r   <= q_nxt;
                    cnt_r <= cnt_r + 5'd1;
                end
                S_NORM: begin
                    z <= norm_z;
                    {nan, zero, underflow, overflow, divzero} <= norm_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
